// File: rtl/warmboot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : warmboot_sequencer
// Description : Drives the iCE40 SB_WARMBOOT primitive. A boot starts either
//               on an explicit request from the bootloader core or, if no USB
//               host activity is seen, after a power-up timeout. The shared
//               SPI flash bus is locked and must be observed idle before the
//               image select is presented. The select is then held for a setup
//               interval, and BOOT is pulsed high for a fixed width.
// Ports       : clk_48mhz    - sole clock (48 MHz)
//               reset_n      - asynchronous active-low reset
//               boot_req     - single-cycle boot request
//               boot_image   - {S1,S0} image, sampled with boot_req
//               usb_activity - host token pulse, permanently cancels auto-boot
//               spi_cs       - flash chip select from the core (active low)
//               spi_lock     - forces spi_cs high / SCK low at the top level
//               wb_s1, wb_s0 - SB_WARMBOOT.S1 / S0
//               wb_boot      - SB_WARMBOOT.BOOT
//               busy         - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module warmboot_sequencer #(
    parameter int         TIMEOUT_CYCLES = 96000000,
    parameter logic [1:0] DEFAULT_IMAGE  = 2'b01,
    parameter int         DRAIN_CYCLES   = 16,
    parameter int         SETUP_CYCLES   = 4,
    parameter int         PULSE_CYCLES   = 8
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       usb_activity,
    input  logic       spi_cs,
    output logic       spi_lock,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam int c_MAX_CNT = (DRAIN_CYCLES > SETUP_CYCLES)
                             ? ((DRAIN_CYCLES > PULSE_CYCLES) ? DRAIN_CYCLES : PULSE_CYCLES)
                             : ((SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES);
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    // The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_AUTO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [c_TO_W-1:0]  c_TO_LAST    = c_AUTO_EN ? c_TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DRAIN = 3'd1;
    localparam logic [2:0] c_ST_SETUP = 3'd2;
    localparam logic [2:0] c_ST_PULSE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state,    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [c_TO_W-1:0]  r_to_cnt,   w_to_cnt_nxt;
    logic               r_auto_dis, w_auto_dis_nxt;
    logic [1:0]         r_sel,      w_sel_nxt;
    logic               w_expire;

    logic r_spi_lock, r_wb_s1, r_wb_s0, r_wb_boot, r_busy;

    // Activity in the expiry cycle itself suppresses the auto-boot.
    assign w_expire = c_AUTO_EN && !r_auto_dis && !usb_activity && (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_auto_dis_nxt = r_auto_dis;
        w_sel_nxt      = r_sel;
        case (r_state)
            c_ST_IDLE: begin
                if (usb_activity) begin
                    w_auto_dis_nxt = 1'b1;
                end
                if (c_AUTO_EN && !r_auto_dis) begin
                    w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
                end
                if (boot_req) begin
                    w_sel_nxt   = boot_image;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DRAIN;
                end else if (w_expire) begin
                    w_sel_nxt   = DEFAULT_IMAGE;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // Counts consecutive idle-bus cycles; any access restarts it.
                if (!spi_cs) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_SETUP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_PULSE: begin
                if (r_cnt == c_PULSE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_DONE: begin
                // Terminal: the device reconfigures out from under us.
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_auto_dis <= 1'b0;
            r_sel      <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_auto_dis <= w_auto_dis_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    // Outputs are registered from the current state so the warmboot pins see
    // clean flop outputs with no input-to-output path.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_spi_lock <= 1'b0;
            r_busy     <= 1'b0;
            r_wb_s1    <= 1'b0;
            r_wb_s0    <= 1'b0;
            r_wb_boot  <= 1'b0;
        end else begin
            r_spi_lock <= (r_state != c_ST_IDLE);
            r_busy     <= (r_state != c_ST_IDLE);
            if ((r_state == c_ST_SETUP) || (r_state == c_ST_PULSE) || (r_state == c_ST_DONE)) begin
                r_wb_s1 <= r_sel[1];
                r_wb_s0 <= r_sel[0];
            end else begin
                r_wb_s1 <= 1'b0;
                r_wb_s0 <= 1'b0;
            end
            r_wb_boot  <= (r_state == c_ST_PULSE);
        end
    end

    assign spi_lock = r_spi_lock;
    assign busy     = r_busy;
    assign wb_s1    = r_wb_s1;
    assign wb_s0    = r_wb_s0;
    assign wb_boot  = r_wb_boot;

endmodule
`default_nettype wire

// File: tb/tb_warmboot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_warmboot_sequencer
// Description : Self-checking bench for warmboot_sequencer. Each scenario
//               queues the output transitions it expects ({cycle, outputs});
//               a monitor pops one entry per observed output change and
//               compares cycle and value. Cycle n is the state after the
//               n-th rising edge following reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warmboot_sequencer;

    logic       clk_48mhz;
    logic       reset_n;
    logic       boot_req;
    logic [1:0] boot_image;
    logic       usb_activity;
    logic       spi_cs;
    logic       spi_lock, wb_s1, wb_s0, wb_boot, busy;

    warmboot_sequencer #(
        .TIMEOUT_CYCLES (100),
        .DEFAULT_IMAGE  (2'b01),
        .DRAIN_CYCLES   (16),
        .SETUP_CYCLES   (4),
        .PULSE_CYCLES   (8)
    ) u_dut (
        .clk_48mhz    (clk_48mhz),
        .reset_n      (reset_n),
        .boot_req     (boot_req),
        .boot_image   (boot_image),
        .usb_activity (usb_activity),
        .spi_cs       (spi_cs),
        .spi_lock     (spi_lock),
        .wb_s1        (wb_s1),
        .wb_s0        (wb_s0),
        .wb_boot      (wb_boot),
        .busy         (busy)
    );

    typedef struct packed {
        logic [31:0] c;
        logic [4:0]  v;   // {busy, spi_lock, wb_s1, wb_s0, wb_boot}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;
    int   base  = 0;

    initial begin
        clk_48mhz = 1'b0;
        forever #5 clk_48mhz = ~clk_48mhz;
    end

    always @(posedge clk_48mhz) edges <= edges + 1;

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    // Returns at the falling edge just before edge n, so inputs set now are
    // sampled at edge n.
    task automatic wait_to(input int n);
        while ((edges - base) < n - 1) @(negedge clk_48mhz);
    endtask

    task automatic request(input int n, input logic [1:0] img);
        wait_to(n);
        boot_image = img;
        boot_req   = 1'b1;
        @(negedge clk_48mhz);
        boot_req   = 1'b0;
        boot_image = 2'b00;
    endtask

    task automatic activity(input int n);
        wait_to(n);
        usb_activity = 1'b1;
        @(negedge clk_48mhz);
        usb_activity = 1'b0;
    endtask

    task automatic check_zero(input string name);
        logic [4:0] cur;
        cur = {busy, spi_lock, wb_s1, wb_s0, wb_boot};
        total++;
        if (cur !== 5'b00000) begin
            bad++;
            $display("FAIL %s outputs=%b required=00000", name, cur);
        end
    endtask

    // Reset asserted just after the next rising edge; outputs must clear
    // immediately. If outputs were non-zero the drop is an expected change.
    task automatic do_reset(input bit drop);
        @(posedge clk_48mhz);
        #1;
        reset_n = 1'b0;
        if (drop) push(edges - base, 5'b00000);
        #1;
        check_zero("async_reset");
        repeat (3) @(negedge clk_48mhz);
        reset_n = 1'b1;
        base    = edges;
    endtask

    // Monitor: one comparison per output change.
    initial begin
        logic [4:0] prev, cur;
        exp_t e;
        prev = 5'b00000;
        forever begin
            @(negedge clk_48mhz);
            cur = {busy, spi_lock, wb_s1, wb_s0, wb_boot};
            if (cur !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d outputs=%b (was %b) required no change",
                             edges - base, cur, prev);
                end else begin
                    e = q.pop_front();
                    if ((int'(e.c) != edges - base) || (e.v !== cur)) begin
                        bad++;
                        $display("FAIL transition got cyc=%0d outputs=%b required cyc=%0d outputs=%b",
                                 edges - base, cur, e.c, e.v);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        reset_n      = 1'b1;
        boot_req     = 1'b0;
        boot_image   = 2'b00;
        usb_activity = 1'b0;
        spi_cs       = 1'b1;
        #1 reset_n   = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) @(negedge clk_48mhz);
        reset_n = 1'b1;
        base    = edges;

        // Explicit boot of image 10, bus idle; a second request in PULSE is ignored.
        push(11, 5'b11000); push(27, 5'b11100); push(31, 5'b11101); push(39, 5'b11100);
        request(10, 2'b10);
        request(34, 2'b01);
        wait_to(60);
        do_reset(1'b1);

        // Drain restart: spi_cs low on edges 19..23, first idle edge 24.
        push(11, 5'b11000); push(40, 5'b11010); push(44, 5'b11011); push(52, 5'b11010);
        request(10, 2'b01);
        wait_to(19); spi_cs = 1'b0;
        wait_to(24); spi_cs = 1'b1;
        wait_to(60);
        do_reset(1'b1);

        // Request with image 11 on the timeout cycle: request wins, one pulse.
        push(101, 5'b11000); push(117, 5'b11110); push(121, 5'b11111); push(129, 5'b11110);
        request(100, 2'b11);
        wait_to(200);
        do_reset(1'b1);

        // Auto-boot, reset on the 3rd BOOT-high cycle, then a full auto-boot
        // from a restarted timeout.
        push(101, 5'b11000); push(117, 5'b11010); push(121, 5'b11011);
        wait_to(123);
        do_reset(1'b1);
        push(101, 5'b11000); push(117, 5'b11010); push(121, 5'b11011); push(129, 5'b11010);
        wait_to(140);
        do_reset(1'b1);

        // Activity on the expiry cycle cancels auto-boot.
        activity(100);
        wait_to(300);
        do_reset(1'b0);

        // Activity one cycle before expiry; later explicit boot still works.
        activity(99);
        wait_to(10000);
        push(10011, 5'b11000); push(10027, 5'b11110); push(10031, 5'b11111); push(10039, 5'b11110);
        request(10010, 2'b11);
        wait_to(10060);

        repeat (2) @(negedge clk_48mhz);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_transitions remaining=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
